// File: rtl/alu_writeback.sv
// ALU writeback stage: commits accum/flags/regfile, skip squash, interrupt shadow stack.
// Optional WB_FORWARD_EN adds a one-deep register-operand bypass.
module alu_writeback #(
  parameter int ADDR_WIDTH   = 8,
  parameter int SHADOW_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [7:0]            result,
  input  logic                  accum_write,
  input  logic                  reg_write,
  input  logic                  z_write,
  input  logic                  zout,
  input  logic                  c_write,
  input  logic                  cout,
  input  logic                  skip,
  input  logic                  retint,
  input  logic                  int_enter,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [7:0]            rf_rdata,
  output logic [7:0]            accum,
  output logic                  cin,
  output logic                  zflag,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [7:0]            rf_wdata,
  output logic                  squash,
  output logic [7:0]            regvalue,
  output logic                  shadow_err
);

  localparam int PW = $clog2(SHADOW_DEPTH) + 1;
  localparam int IW = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;
  localparam logic [PW-1:0] FULL = PW'(SHADOW_DEPTH);
  localparam logic [PW-1:0] ONE  = PW'(1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ARMED = 1'b1;

  logic [0:0]    state;
  logic [PW-1:0] sp;
  logic [PW-1:0] sp_pop;
  logic [9:0]    stack [SHADOW_DEPTH];
  logic [9:0]    top;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] push_idx;
  logic          commit;
  logic          pop_ok;
  logic          pop_err;
  logic          push_ok;
  logic          push_err;
  logic [7:0]    acc_n;
  logic          z_n;
  logic          c_n;

  // Commit/squash decode, next architectural state and stack pointer moves
  always_comb begin
    commit   = in_valid && (state == IDLE);
    squash   = in_valid && (state == ARMED);
    pop_ok   = commit && retint && (sp != '0);
    pop_err  = commit && retint && (sp == '0);
    sp_pop   = pop_ok ? sp - ONE : sp;
    push_ok  = int_enter && (sp_pop != FULL);
    push_err = int_enter && (sp_pop == FULL);
    top_idx  = IW'(sp - ONE);
    push_idx = IW'(sp_pop);
    top      = stack[top_idx];
    acc_n    = accum;
    z_n      = zflag;
    c_n      = cin;
    if (commit && accum_write) acc_n = result;
    if (commit && z_write)     z_n   = zout;
    if (commit && c_write)     c_n   = cout;
    if (pop_ok) begin
      acc_n = top[9:2];
      z_n   = top[1];
      c_n   = top[0];
    end
  end

  // Skip tracker: arm on a committed skip, disarm on the next real instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (commit && skip) state <= ARMED;
        ARMED:   if (in_valid)       state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Architectural state, register write port and shadow pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      accum      <= '0;
      zflag      <= 1'b0;
      cin        <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      sp         <= '0;
      shadow_err <= 1'b0;
    end else begin
      accum <= acc_n;
      zflag <= z_n;
      cin   <= c_n;
      rf_we <= commit && reg_write;
      if (commit && reg_write) begin
        rf_waddr <= in_addr;
        rf_wdata <= result;
      end
      sp <= push_ok ? sp_pop + ONE : sp_pop;
      if (pop_err || push_err) shadow_err <= 1'b1;
    end
  end

  // Shadow storage; the entry holds post-commit (or restored) context
  always_ff @(posedge clk) begin
    if (push_ok) stack[push_idx] <= {acc_n, z_n, c_n};
  end

`ifdef WB_FORWARD_EN
  // Bypass the write landing this cycle onto the dependent read
  always_comb begin
    regvalue = rf_rdata;
    if (rf_we && (rf_waddr == rd_addr)) regvalue = rf_wdata;
  end
`else
  // No bypass; a bubble separates dependent instructions
  always_comb begin
    regvalue = rf_rdata;
  end
`endif

endmodule
